counter_seq_ctrl: RTL and testbench

- Sequencer and arbiter in front of the existing loadable 8-bit counter.
- Two requesters (A: host pins, B: internal preset source) compete to load a start value into the counter.
- The block grants one requester (round-robin), drives a one-cycle load, then holds the counter's output enable for a programmed run window.
- It sits between the top-level pin decode and the counter instance, and owns the counter's load_en, load_val and oe.

---
 rtl/counter_seq_ctrl_pkg.sv | 9 +
 rtl/counter_seq_ctrl_arb.sv | 28 ++
 rtl/counter_seq_ctrl.sv | 94 +++++++++
 tb/tb_counter_seq_ctrl.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types and constants for the counter load sequencer.
package counter_seq_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int LEN_W_DEF = 8;
  localparam int REQ_A     = 0;
  localparam int REQ_B     = 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_e;
endpackage

// File: rtl/counter_seq_ctrl_arb.sv
// Two-way round-robin arbiter; the pointer moves past the winner on every grant.
module rr_arbiter2
  import counter_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);
  // ptr_q = 0 prefers A, 1 prefers B
  logic ptr_q, ptr_d;

  always_comb begin
    gnt_o = 2'b00;
    ptr_d = ptr_q;
    if (en_i) begin
      if (req_i == 2'b11) gnt_o = ptr_q ? 2'b10 : 2'b01;
      else                gnt_o = req_i;
      if (|req_i) ptr_d = gnt_o[REQ_A];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
endmodule

// File: rtl/counter_seq_ctrl.sv
// Arbitrates two load requesters, pulses the counter load, then holds oe for a run window.
module counter_seq_ctrl
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_a,
  input  logic [WIDTH-1:0] val_a,
  output logic             gnt_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] val_b,
  output logic             gnt_b,
  input  logic [LEN_W-1:0] run_len,
  output logic             cnt_load_en,
  output logic [WIDTH-1:0] cnt_load_val,
  output logic             cnt_oe,
  output logic             busy,
  output logic             done
);
  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] timer_q, timer_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       arb_gnt;
  logic             arb_en;
  logic             len_zero;

  assign len_zero = (len_q == '0);
  // A continuous run stays open to preemption; a finite run makes requesters wait.
  assign arb_en   = (state_q == S_IDLE) || ((state_q == S_RUN) && len_zero);

  rr_arbiter2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .en_i  (arb_en),
    .req_i ({req_b, req_a}),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    timer_d = timer_q;
    val_d   = val_q;
    gnt_d   = 2'b00;
    case (state_q)
      S_LOAD: begin
        state_d = S_RUN;
        timer_d = len_zero ? '0 : len_q - LEN_W'(1);
      end
      S_RUN: begin
        if (!len_zero) begin
          if (timer_q == '0) state_d = S_IDLE;
          else               timer_d = timer_q - LEN_W'(1);
        end
      end
      default: ;
    endcase
    if (|arb_gnt) begin
      gnt_d   = arb_gnt;
      val_d   = arb_gnt[REQ_B] ? val_b : val_a;
      len_d   = run_len;
      state_d = S_LOAD;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      timer_q <= '0;
      val_q   <= '0;
      gnt_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      timer_q <= timer_d;
      val_q   <= val_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt_a        = gnt_q[REQ_A];
  assign gnt_b        = gnt_q[REQ_B];
  assign cnt_load_en  = (state_q == S_LOAD);
  assign cnt_load_val = val_q;
  assign cnt_oe       = (state_q == S_RUN);
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_RUN) && !len_zero && (timer_q == '0);
endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboarded bench: drivers queue expected grants, a negedge monitor checks each cycle.
module tb_counter_seq_ctrl;
  logic       clk = 1'b0, rst = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic [7:0] val_a = '0, val_b = '0, run_len = '0;
  logic       gnt_a, gnt_b, cnt_load_en, cnt_oe, busy, done;
  logic [7:0] cnt_load_val;

  counter_seq_ctrl #(.WIDTH(8), .LEN_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .val_a(val_a), .gnt_a(gnt_a),
    .req_b(req_b), .val_b(val_b), .gnt_b(gnt_b),
    .run_len(run_len),
    .cnt_load_en(cnt_load_en), .cnt_load_val(cnt_load_val),
    .cnt_oe(cnt_oe), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { bit side; logic [7:0] val; int len; } exp_t;
  exp_t q[$];
  exp_t me;
  int   npass = 0, ntot = 0;
  bit   ptr = 1'b0;
  int   phase = 0, left = 0;
  bit   need_idle = 1'b0;

  task automatic check(string name, bit ok, int act, int exp);
    ntot++;
    if (ok) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference: each grant carries side/value/length; pointer moves past the winner.
  task automatic expect_grant(bit side, logic [7:0] val, int len);
    q.push_back('{side, val, len});
    ptr = !side;
  endtask

  // phase: 0 idle, 1 finite window with `left` cycles remaining, 2 continuous
  always @(negedge clk) begin
    if (rst) begin
      phase = 0; left = 0; need_idle = 1'b0;
    end else if (gnt_a || gnt_b) begin
      if (q.size() == 0) begin
        check("unexpected_gnt", 1'b0, int'({gnt_b, gnt_a}), 0);
      end else begin
        me = q.pop_front();
        check("gnt_side", (gnt_a == !me.side) && (gnt_b == me.side),
              int'({gnt_b, gnt_a}), me.side ? 2 : 1);
        check("load_val", cnt_load_val == me.val, int'(cnt_load_val), int'(me.val));
        check("load_cycle", cnt_load_en && !cnt_oe && busy && !done,
              int'({cnt_load_en, cnt_oe, busy, done}), 'b1010);
        check("early_gnt", !need_idle && (phase != 1), int'({need_idle, phase[1:0]}), 0);
        phase = (me.len == 0) ? 2 : 1;
        left  = me.len;
        need_idle = 1'b0;
      end
    end else begin
      case (phase)
        1: begin
          check("run_finite", cnt_oe && busy && !cnt_load_en && (done == (left == 1)),
                int'({cnt_oe, busy, cnt_load_en, done}), int'({3'b110, left == 1}));
          left--;
          if (left == 0) begin phase = 0; need_idle = 1'b1; end
        end
        2: check("run_cont", cnt_oe && busy && !cnt_load_en && !done,
                 int'({cnt_oe, busy, cnt_load_en, done}), 'b1100);
        default: begin
          check("idle", !busy && !cnt_oe && !cnt_load_en && !done,
                int'({cnt_oe, busy, cnt_load_en, done}), 0);
          need_idle = 1'b0;
        end
      endcase
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  // Hold requests until granted, dropping each one as soon as its grant is seen.
  task automatic serve();
    int t = 0;
    while ((req_a || req_b) && t < 200) begin
      tick(); t++;
      if (gnt_a) req_a = 1'b0;
      if (gnt_b) req_b = 1'b0;
    end
    if (req_a || req_b) begin
      check("serve_timeout", 1'b0, t, 200);
      req_a = 1'b0; req_b = 1'b0;
    end
  endtask

  task automatic do_reset(int cycles);
    rst = 1'b1; q.delete(); ptr = 1'b0;
    tick(cycles);
    check("rst_outs", ({gnt_a, gnt_b, cnt_load_en, cnt_oe, busy, done} == 6'b0) &&
          (cnt_load_val == 8'h00),
          int'({gnt_a, gnt_b, cnt_load_en, cnt_oe, busy, done, cnt_load_val}), 0);
    rst = 1'b0;
  endtask

  initial begin
    bit w;
    int mode;
    do_reset(2);

    // single request
    run_len = 8'd3; val_a = 8'h3C;
    expect_grant(1'b0, val_a, 3); req_a = 1'b1; serve(); tick(6);

    // simultaneous from fresh reset: A first, then B after an idle cycle
    do_reset(2);
    run_len = 8'd1; val_a = 8'h11; val_b = 8'h22;
    w = ptr;
    expect_grant(w, w ? val_b : val_a, 1);
    expect_grant(!w, w ? val_a : val_b, 1);
    req_a = 1'b1; req_b = 1'b1; serve(); tick(6);
    check("ptr_back_to_a", ptr == 1'b0, int'(ptr), 0);

    // request arriving during a finite run waits for idle
    run_len = 8'd5; val_a = 8'($urandom); val_b = 8'($urandom);
    expect_grant(1'b0, val_a, 5); req_a = 1'b1; serve();
    tick(2);
    expect_grant(1'b1, val_b, 5); req_b = 1'b1; serve(); tick(10);

    // run_len change after capture is ignored
    run_len = 8'd4; val_a = 8'($urandom);
    expect_grant(1'b0, val_a, 4); req_a = 1'b1; serve();
    tick(1); run_len = 8'd9; tick(8);

    // continuous run then preemption by B
    run_len = 8'd0; val_a = 8'h05;
    expect_grant(1'b0, val_a, 0); req_a = 1'b1; serve();
    tick(50);
    run_len = 8'd2; val_b = 8'hF0;
    expect_grant(1'b1, val_b, 2); req_b = 1'b1; serve(); tick(6);

    // reset mid-run with A re-requesting; A regranted after release
    run_len = 8'd10; val_a = 8'($urandom);
    expect_grant(1'b0, val_a, 10); req_a = 1'b1; serve();
    tick(1); req_a = 1'b1; tick(3);
    do_reset(1);
    expect_grant(1'b0, val_a, 10); serve(); tick(14);

    // randomized mix of single and simultaneous requests
    for (int i = 0; i < 24; i++) begin
      mode = $urandom_range(0, 2);
      run_len = 8'($urandom_range(1, 6));
      val_a = 8'($urandom); val_b = 8'($urandom);
      if (mode == 0) begin
        expect_grant(1'b0, val_a, int'(run_len)); req_a = 1'b1;
      end else if (mode == 1) begin
        expect_grant(1'b1, val_b, int'(run_len)); req_b = 1'b1;
      end else begin
        w = ptr;
        expect_grant(w, w ? val_b : val_a, int'(run_len));
        expect_grant(!w, w ? val_a : val_b, int'(run_len));
        req_a = 1'b1; req_b = 1'b1;
      end
      serve();
      tick($urandom_range(0, 8));
    end

    tick(20);
    check("queue_drained", q.size() == 0, q.size(), 0);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
